// File: rtl/hs_pkg.sv
// Shared types and constants for the four-phase req/ack byte handshake.
// MASTER_FSM_TIMEOUT_EN widens master_state_t to add the ERR state.
package hs_pkg;

    localparam int unsigned HS_BYTE_W        = 8;
    localparam int unsigned HS_BURST_LEN_DEF = 4;
    localparam int unsigned HS_TIMEOUT_DEF   = 15;

`ifdef MASTER_FSM_TIMEOUT_EN
    typedef enum logic [2:0] {
        M_IDLE     = 3'd0,
        M_REQ      = 3'd1,
        M_WAIT_LOW = 3'd2,
        M_DONE     = 3'd3,
        M_ERR      = 3'd4
    } master_state_t;
`else
    typedef enum logic [1:0] {
        M_IDLE     = 2'd0,
        M_REQ      = 2'd1,
        M_WAIT_LOW = 2'd2,
        M_DONE     = 2'd3
    } master_state_t;
`endif

endpackage

// File: rtl/hs_timeout_ctr.sv
// Per-phase wait counter; expired flags TIMEOUT cycles spent in one handshake phase.
// Only instantiated by master_fsm when MASTER_FSM_TIMEOUT_EN is defined.
module hs_timeout_ctr
    import hs_pkg::*;
#(
    parameter int unsigned TIMEOUT = HS_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate at TIMEOUT so a stalled phase cannot wrap back below the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/master_fsm.sv
// Initiator of the four-phase req/ack byte handshake: sends BURST_LEN bytes from base_byte.
// Optional handshake timeout (ERR state, err_out pulse) under MASTER_FSM_TIMEOUT_EN.
module master_fsm
    import hs_pkg::*;
#(
    parameter int unsigned BURST_LEN = HS_BURST_LEN_DEF,
    parameter int unsigned TIMEOUT   = HS_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [HS_BYTE_W-1:0] base_byte,
    input  logic                 ack_in,
    output logic                 req_out,
    output logic [HS_BYTE_W-1:0] data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err_out
);

    localparam logic [HS_BYTE_W-1:0] LAST_IDX = HS_BYTE_W'(BURST_LEN - 1);

    if (BURST_LEN < 1 || BURST_LEN > (1 << HS_BYTE_W)) begin : g_bad_burst_len
        $error("master_fsm: BURST_LEN must be within 1..256");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("master_fsm: TIMEOUT must be at least 1");
    end

    master_state_t        state_q;
    logic [HS_BYTE_W-1:0] cnt_q;
    logic [HS_BYTE_W-1:0] data_q;
    logic                 req_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 last_c;

    assign last_c = (cnt_q == LAST_IDX);

`ifdef MASTER_FSM_TIMEOUT_EN
    logic tmo_clr_c;
    logic tmo_en_c;
    logic tmo_expired_c;

    // Clear on every edge that enters REQ or WAIT_LOW so each phase gets a fresh budget.
    always_comb begin
        tmo_clr_c = 1'b0;
        unique case (state_q)
            M_IDLE:     tmo_clr_c = start;
            M_REQ:      tmo_clr_c = ack_in;
            M_WAIT_LOW: tmo_clr_c = !ack_in && !last_c;
            default:    tmo_clr_c = 1'b0;
        endcase
    end

    assign tmo_en_c = (state_q == M_REQ) || (state_q == M_WAIT_LOW);

    hs_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr_c),
        .en      (tmo_en_c),
        .expired (tmo_expired_c)
    );
`endif

    // Outputs are updated together with the state so they all appear one cycle after their cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= M_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                M_IDLE: begin
                    if (start) begin
                        state_q <= M_REQ;
                        cnt_q   <= '0;
                        data_q  <= base_byte;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                M_REQ: begin
                    if (ack_in) begin
                        state_q <= M_WAIT_LOW;
                        req_q   <= 1'b0;
                    end
`ifdef MASTER_FSM_TIMEOUT_EN
                    else if (tmo_expired_c) begin
                        state_q <= M_ERR;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end
`endif
                end
                M_WAIT_LOW: begin
                    if (!ack_in) begin
                        if (last_c) begin
                            state_q <= M_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= M_REQ;
                            cnt_q   <= cnt_q + HS_BYTE_W'(1);
                            data_q  <= data_q + HS_BYTE_W'(1);
                            req_q   <= 1'b1;
                        end
                    end
`ifdef MASTER_FSM_TIMEOUT_EN
                    else if (tmo_expired_c) begin
                        state_q <= M_ERR;
                        err_q   <= 1'b1;
                    end
`endif
                end
                M_DONE: begin
                    state_q <= M_IDLE;
                    busy_q  <= 1'b0;
                end
`ifdef MASTER_FSM_TIMEOUT_EN
                M_ERR: begin
                    state_q <= M_IDLE;
                    busy_q  <= 1'b0;
                end
`endif
                default: begin
                    state_q <= M_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_out  = req_q;
    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_out  = err_q;

endmodule

// File: tb/tb_master_fsm.sv
// Scoreboard bench for master_fsm: responder stub (fast/slow/silent slave), byte and event queues.
// Honours MASTER_FSM_TIMEOUT_EN to select the timeout expectations.
module tb_master_fsm;
    import hs_pkg::*;

    localparam int unsigned BL = 4;
    localparam int unsigned TO = 15;

    typedef struct {
        bit is_err;
        int at;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base_byte;
    logic       ack_in;
    logic       req_out;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       err_out;

    master_fsm #(
        .BURST_LEN (BL),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_byte (base_byte),
        .ack_in    (ack_in),
        .req_out   (req_out),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .err_out   (err_out)
    );

    int         cyc;
    int         n_chk;
    int         n_fail;
    int         mode;      // 0: slave-like ack, 1: slow stub, 2: ack tied low
    int         sl_cnt;
    logic       req_s;
    logic [7:0] byte_q[$];
    ev_t        ev_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [7:0] b);
        for (int k = 0; k < int'(BL); k++) byte_q.push_back(8'(b + k));
    endtask

    task automatic push_ev(input bit is_err, input int at);
        ev_t e;
        e.is_err = is_err;
        e.at     = at;
        ev_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        check(name, int'(busy), 0);
        step();
        step();
        step();
    endtask

    // Responder: decides ack for the next cycle from what req_out was during the cycle just ended.
    initial begin
        ack_in = 1'b0;
        sl_cnt = 0;
        forever begin
            @(negedge clk);
            req_s = req_out;
            @(posedge clk);
            #1;
            case (mode)
                0: ack_in = req_s;
                1: begin
                    if (sl_cnt == 7)     sl_cnt = 0;
                    else if (sl_cnt > 0) sl_cnt++;
                    else if (req_s)      sl_cnt = 1;
                    ack_in = (sl_cnt >= 5 && sl_cnt <= 7);
                end
                default: ack_in = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted byte and every done/err pulse.
    initial begin
        logic       prev_req;
        logic       prev_ack;
        logic [7:0] prev_data;
        ev_t        e;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (req_out && !prev_req) check("req_rise_ack_low", int'(prev_ack), 0);
            if (req_out && prev_req)  check("data_stable", int'(data_out), int'(prev_data));
            if (req_out && ack_in) begin
                if (byte_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none (cycle %0d)", data_out, cyc);
                end else begin
                    check("byte", int'(data_out), int'(byte_q.pop_front()));
                end
            end
            if (done || err_out) begin
                if (ev_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: got done=%0b err=%0b, expected none (cycle %0d)",
                             done, err_out, cyc);
                end else begin
                    e = ev_q.pop_front();
                    check("event_kind", int'({done, err_out}), e.is_err ? 1 : 2);
                    check("event_cycle", cyc, e.at);
                end
            end
            prev_req  = req_out;
            prev_ack  = ack_in;
            prev_data = data_out;
        end
    end

    initial begin
        int t0;
        n_chk     = 0;
        n_fail    = 0;
        mode      = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base_byte = '0;
        step();
        step();
        @(negedge clk);
        check("rst_req", int'(req_out), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err_out), 0);
        step();
        rst = 1'b0;
        step();

        // Burst at 0x10, ignored starts in cycles 3 and 17, wrap burst accepted in cycle 18.
        t0 = cyc;
        push_burst(8'h10);
        push_ev(1'b0, t0 + 17);
        start     = 1'b1;
        base_byte = 8'h10;
        @(negedge clk);
        check("c0_busy", int'(busy), 0);
        for (int i = 1; i <= 18; i++) begin
            step();
            start     = (i == 3 || i == 17 || i == 18);
            base_byte = (i == 18) ? 8'hFE : 8'h77;
            if (i == 18) begin
                push_burst(8'hFE);
                push_ev(1'b0, cyc + 17);
            end
            @(negedge clk);
            if (i == 1) begin
                check("c1_req", int'(req_out), 1);
                check("c1_data", int'(data_out), 8'h10);
                check("c1_busy", int'(busy), 1);
            end
            if (i == 3)  check("c3_req", int'(req_out), 0);
            if (i == 5)  check("c5_data", int'(data_out), 8'h11);
            if (i == 13) check("c13_req", int'(req_out), 1);
            if (i == 17) check("c17_busy", int'(busy), 1);
            if (i == 18) check("c18_busy", int'(busy), 0);
        end
        step();
        start = 1'b0;
        @(negedge clk);
        check("c19_req", int'(req_out), 1);
        check("c19_data", int'(data_out), 8'hFE);
        check("c19_busy", int'(busy), 1);
        wait_idle("wrap_idle");

        // Slow stub: ack five cycles after req, held for three.
        mode = 1;
        step();
        t0 = cyc;
        push_burst(8'h40);
        push_ev(1'b0, t0 + 37);
        start     = 1'b1;
        base_byte = 8'h40;
        for (int i = 1; i <= 10; i++) begin
            step();
            start = 1'b0;
            @(negedge clk);
            if (i == 5) begin
                check("slow_c5_req", int'(req_out), 1);
                check("slow_c5_data", int'(data_out), 8'h40);
            end
            if (i == 7)  check("slow_c7_req", int'(req_out), 0);
            if (i == 8)  check("slow_c8_req", int'(req_out), 0);
            if (i == 10) check("slow_c10_data", int'(data_out), 8'h41);
        end
        wait_idle("slow_idle");
        mode = 0;
        step();
        step();

        // Reset in cycle 6 abandons the burst after two bytes.
        t0 = cyc;
        push_burst(8'h55);
        void'(byte_q.pop_back());
        void'(byte_q.pop_back());
        start     = 1'b1;
        base_byte = 8'h55;
        for (int i = 1; i <= 9; i++) begin
            step();
            start = 1'b0;
            rst   = (i == 6);
            @(negedge clk);
            if (i == 7) begin
                check("rst_c7_req", int'(req_out), 0);
                check("rst_c7_data", int'(data_out), 0);
                check("rst_c7_busy", int'(busy), 0);
            end
            if (i == 9) check("rst_c9_req", int'(req_out), 0);
        end
        repeat (20) step();

        // Silent slave: timeout pulse or indefinite wait.
        mode = 2;
        step();
        t0 = cyc;
`ifdef MASTER_FSM_TIMEOUT_EN
        push_ev(1'b1, t0 + 17);
`endif
        start     = 1'b1;
        base_byte = 8'h20;
        for (int i = 1; i <= 40; i++) begin
            step();
            start = 1'b0;
            @(negedge clk);
            if (i == 1) begin
                check("tmo_c1_req", int'(req_out), 1);
                check("tmo_c1_data", int'(data_out), 8'h20);
            end
`ifdef MASTER_FSM_TIMEOUT_EN
            if (i == 16) check("tmo_c16_req", int'(req_out), 1);
            if (i == 17) check("tmo_c17_busy", int'(busy), 1);
            if (i == 18) begin
                check("tmo_c18_req", int'(req_out), 0);
                check("tmo_c18_busy", int'(busy), 0);
            end
`else
            if (i == 40) begin
                check("hold_c40_req", int'(req_out), 1);
                check("hold_c40_busy", int'(busy), 1);
                check("hold_c40_data", int'(data_out), 8'h20);
            end
`endif
        end
`ifndef MASTER_FSM_TIMEOUT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif
        step();
        @(negedge clk);
        check("end_req", int'(req_out), 0);
        check("end_busy", int'(busy), 0);
        repeat (3) step();
        check("bytes_left", byte_q.size(), 0);
        check("events_left", ev_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
